// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing the registerset write port and read port 1 between two requesters.
// Write acks 2 cycles after the grant sample, reads RD_LAT+1; requesters hold req until ack, no abort.
module regfile_arbiter #(
  parameter int DataWidth = 8,
  parameter int SEL_WIDTH = 2,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 wr0,
  input  logic                 wr1,
  input  logic [SEL_WIDTH-1:0] sel0,
  input  logic [SEL_WIDTH-1:0] sel1,
  input  logic [DataWidth-1:0] wdata0,
  input  logic [DataWidth-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [DataWidth-1:0] rdata0,
  output logic [DataWidth-1:0] rdata1,
  output logic                 busy,
  output logic                 wr_en,
  output logic [SEL_WIDTH-1:0] wr_sel,
  output logic [DataWidth-1:0] reg_in,
  output logic                 rd_en1,
  output logic [SEL_WIDTH-1:0] rd_sel1,
  input  logic [DataWidth-1:0] reg_out_1
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

  localparam logic [2:0] CntLast = 3'(RD_LAT - 1);

  state_t               state, state_nxt;
  logic                 last, last_nxt;
  logic                 gnt, gnt_nxt;
  logic [2:0]           cnt, cnt_nxt;
  logic                 ack0_nxt, ack1_nxt, busy_nxt, wr_en_nxt, rd_en1_nxt;
  logic [DataWidth-1:0] rdata0_nxt, rdata1_nxt, reg_in_nxt;
  logic [SEL_WIDTH-1:0] wr_sel_nxt, rd_sel1_nxt;

  logic                 pick, pick_wr;
  logic [SEL_WIDTH-1:0] pick_sel;
  logic [DataWidth-1:0] pick_wdata;

  // On contention the requester that was not served last wins.
  assign pick       = req1 & (~req0 | ~last);
  assign pick_wr    = pick ? wr1 : wr0;
  assign pick_sel   = pick ? sel1 : sel0;
  assign pick_wdata = pick ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= IDLE;
      last    <= 1'b1;
      gnt     <= 1'b0;
      cnt     <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      reg_in  <= '0;
      rd_en1  <= 1'b0;
      rd_sel1 <= '0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      gnt     <= gnt_nxt;
      cnt     <= cnt_nxt;
      ack0    <= ack0_nxt;
      ack1    <= ack1_nxt;
      rdata0  <= rdata0_nxt;
      rdata1  <= rdata1_nxt;
      busy    <= busy_nxt;
      wr_en   <= wr_en_nxt;
      wr_sel  <= wr_sel_nxt;
      reg_in  <= reg_in_nxt;
      rd_en1  <= rd_en1_nxt;
      rd_sel1 <= rd_sel1_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    gnt_nxt     = gnt;
    cnt_nxt     = cnt;
    ack0_nxt    = 1'b0;
    ack1_nxt    = 1'b0;
    rdata0_nxt  = rdata0;
    rdata1_nxt  = rdata1;
    wr_en_nxt   = 1'b0;
    wr_sel_nxt  = '0;
    reg_in_nxt  = '0;
    rd_en1_nxt  = 1'b0;
    rd_sel1_nxt = '0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt_nxt = pick;
          if (pick_wr) begin
            state_nxt  = WRITE;
            wr_en_nxt  = 1'b1;
            wr_sel_nxt = pick_sel;
            reg_in_nxt = pick_wdata;
          end else begin
            state_nxt   = READ;
            rd_en1_nxt  = 1'b1;
            rd_sel1_nxt = pick_sel;
            cnt_nxt     = '0;
          end
        end
      end
      WRITE: begin
        state_nxt = ACK;
        ack0_nxt  = ~gnt;
        ack1_nxt  = gnt;
        last_nxt  = gnt;
      end
      READ: begin
        if (cnt == CntLast) begin
          state_nxt = ACK;
          ack0_nxt  = ~gnt;
          ack1_nxt  = gnt;
          last_nxt  = gnt;
          if (gnt) rdata1_nxt = reg_out_1;
          else     rdata0_nxt = reg_out_1;
        end else begin
          cnt_nxt     = cnt + 3'd1;
          rd_en1_nxt  = 1'b1;
          rd_sel1_nxt = rd_sel1;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy_nxt = (state_nxt != IDLE);

  assert property (@(posedge clk) disable iff (res) !(wr_en && rd_en1));

endmodule
